grid_debinarizer: RTL and testbench

- Reverse direction of the tile-energy binarizer. It accepts one binarized 25-pixel grid row at a time plus that row's threshold mean, and expands the row back into a serial 8-bit grayscale pixel stream.
- Reconstruction is two-level: a 1 bit maps to mean+DELTA and a 0 bit maps to mean−DELTA, both saturated.
- Sits after the binary grid store and feeds the display/debug pixel path. Targets Tang Nano 9K at 27 MHz.

---
 rtl/atomik_grid_pkg.sv | 16 +
 rtl/recon_level_calc.sv | 18 +
 rtl/grid_debinarizer.sv | 156 +++++++++++++++
 tb/tb_grid_debinarizer.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/atomik_grid_pkg.sv
// Shared constants and types for the binary-grid pixel path.
package atomik_grid_pkg;

  localparam int unsigned GRID_W = 25;
  localparam int unsigned GRID_H = 25;
  localparam int unsigned COL_W  = $clog2(GRID_W);
  localparam int unsigned ROW_W  = $clog2(GRID_H);

  localparam logic [7:0] DEFAULT_DELTA = 8'd32;

  typedef enum logic {
    StIdle = 1'b0,
    StEmit = 1'b1
  } grid_state_e;

endpackage

// File: rtl/recon_level_calc.sv
// Saturating two-level reconstruction: hi = min(mean+delta,255), lo = max(mean-delta,0).
module recon_level_calc (
  input  logic [7:0] mean_i,
  input  logic [7:0] delta_i,
  output logic [7:0] hi_o,
  output logic [7:0] lo_o
);

  logic [8:0] sum;

  // 9-bit sum exposes the carry used for the upper clamp
  always_comb begin
    sum  = {1'b0, mean_i} + {1'b0, delta_i};
    hi_o = sum[8] ? 8'hFF : sum[7:0];
    lo_o = (mean_i < delta_i) ? 8'h00 : (mean_i - delta_i);
  end

endmodule

// File: rtl/grid_debinarizer.sv
// Expands one binarized grid row at a time into a serial 8-bit pixel stream.
module grid_debinarizer
  import atomik_grid_pkg::*;
#(
  parameter int unsigned GridW = GRID_W,
  parameter int unsigned GridH = GRID_H,
  parameter logic [7:0]  Delta = DEFAULT_DELTA
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       frame_sync_i,
  input  logic [GridW-1:0]           row_bits_i,
  input  logic [7:0]                 row_mean_i,
  input  logic                       row_valid_i,
  output logic                       row_ready_o,
  output logic [7:0]                 pixel_out_o,
  output logic                       pixel_valid_o,
  input  logic                       pixel_ready_i,
  output logic                       pixel_last_col_o,
  output logic                       frame_end_o,
  output logic [$clog2(GridH)-1:0]   row_idx_o,
  output logic [$clog2(GridW)-1:0]   col_idx_o
);

  localparam int unsigned ColW = $clog2(GridW);
  localparam int unsigned RowW = $clog2(GridH);
  localparam logic [ColW-1:0] LastCol = ColW'(GridW - 1);
  localparam logic [RowW-1:0] LastRow = RowW'(GridH - 1);

  grid_state_e     state_q, state_d;
  logic [GridW-1:0] shift_q, shift_d;
  logic [7:0]      hi_q, hi_d, lo_q, lo_d;
  logic [7:0]      pix_q, pix_d;
  logic            pix_valid_q, pix_valid_d;
  logic            row_ready_q, row_ready_d;
  logic            last_col_q, last_col_d;
  logic            frame_end_q, frame_end_d;
  logic [ColW-1:0] col_q, col_d;
  logic [RowW-1:0] row_q, row_d;

  logic [7:0] calc_hi, calc_lo;
  logic       row_hs, pix_hs;

  recon_level_calc u_calc (
    .mean_i  (row_mean_i),
    .delta_i (Delta),
    .hi_o    (calc_hi),
    .lo_o    (calc_lo)
  );

  assign row_hs = row_valid_i && row_ready_q;
  assign pix_hs = pix_valid_q && pixel_ready_i;

  // Next-state: frame_sync overrides everything, otherwise IDLE/EMIT sequencing
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    pix_d       = pix_q;
    pix_valid_d = pix_valid_q;
    row_ready_d = row_ready_q;
    last_col_d  = last_col_q;
    frame_end_d = frame_end_q;
    col_d       = col_q;
    row_d       = row_q;

    if (frame_sync_i) begin
      state_d     = StIdle;
      pix_valid_d = 1'b0;
      last_col_d  = 1'b0;
      frame_end_d = 1'b0;
      row_d       = '0;
      col_d       = '0;
      row_ready_d = 1'b1;
    end else begin
      case (state_q)
        StIdle: begin
          row_ready_d = 1'b1;
          if (row_hs) begin
            // Column 0 is presented on the same edge the row is captured
            shift_d     = row_bits_i;
            hi_d        = calc_hi;
            lo_d        = calc_lo;
            row_ready_d = 1'b0;
            state_d     = StEmit;
            pix_valid_d = 1'b1;
            pix_d       = row_bits_i[0] ? calc_hi : calc_lo;
            col_d       = '0;
            last_col_d  = (LastCol == '0);
            frame_end_d = last_col_d && (row_q == LastRow);
          end
        end
        StEmit: begin
          if (pix_hs) begin
            if (col_q == LastCol) begin
              pix_valid_d = 1'b0;
              row_ready_d = 1'b1;
              state_d     = StIdle;
              row_d       = (row_q == LastRow) ? '0 : row_q + 1'b1;
              col_d       = '0;
              last_col_d  = 1'b0;
              frame_end_d = 1'b0;
            end else begin
              // shift_q[0] is the column on the output; bit 1 is the next one
              pix_d       = shift_q[1] ? hi_q : lo_q;
              shift_d     = shift_q >> 1;
              col_d       = col_q + 1'b1;
              last_col_d  = (col_d == LastCol);
              frame_end_d = last_col_d && (row_q == LastRow);
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State and registered outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      shift_q     <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      pix_q       <= '0;
      pix_valid_q <= 1'b0;
      row_ready_q <= 1'b0;
      last_col_q  <= 1'b0;
      frame_end_q <= 1'b0;
      col_q       <= '0;
      row_q       <= '0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      pix_q       <= pix_d;
      pix_valid_q <= pix_valid_d;
      row_ready_q <= row_ready_d;
      last_col_q  <= last_col_d;
      frame_end_q <= frame_end_d;
      col_q       <= col_d;
      row_q       <= row_d;
    end
  end

  assign row_ready_o      = row_ready_q;
  assign pixel_out_o      = pix_q;
  assign pixel_valid_o    = pix_valid_q;
  assign pixel_last_col_o = last_col_q;
  assign frame_end_o      = frame_end_q;
  assign row_idx_o        = row_q;
  assign col_idx_o        = col_q;

endmodule

// File: tb/tb_grid_debinarizer.sv
// Self-checking bench for grid_debinarizer against a per-pixel arithmetic model.
module tb_grid_debinarizer;

  localparam int W = 25;
  localparam int H = 25;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        frame_sync;
  logic [24:0] row_bits;
  logic [7:0]  row_mean;
  logic        row_valid;
  logic        row_ready;
  logic [7:0]  pixel_out;
  logic        pixel_valid;
  logic        pixel_ready;
  logic        last_col;
  logic        frame_end;
  logic [4:0]  row_idx;
  logic [4:0]  col_idx;

  int passes = 0;
  int total  = 0;
  int model_row = 0;

  typedef struct {
    logic [24:0] bits;
    int          mean;
    bit          rnd;
    int          exp_first;
    int          exp_last;
  } vec_t;

  vec_t vecs[6];

  grid_debinarizer dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .frame_sync_i     (frame_sync),
    .row_bits_i       (row_bits),
    .row_mean_i       (row_mean),
    .row_valid_i      (row_valid),
    .row_ready_o      (row_ready),
    .pixel_out_o      (pixel_out),
    .pixel_valid_o    (pixel_valid),
    .pixel_ready_i    (pixel_ready),
    .pixel_last_col_o (last_col),
    .frame_end_o      (frame_end),
    .row_idx_o        (row_idx),
    .col_idx_o        (col_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Two-level reconstruction straight from the rules, with integer clamps
  function automatic int exp_pix(input logic [24:0] bits, input int mean, input int col);
    int hi;
    int lo;
    hi = mean + 32;
    if (hi > 255) hi = 255;
    lo = mean - 32;
    if (lo < 0) lo = 0;
    return bits[col] ? hi : lo;
  endfunction

  task automatic pulse_sync();
    frame_sync = 1'b1;
    @(negedge clk);
    frame_sync = 1'b0;
    model_row = 0;
  endtask

  // Sends one row and checks every pixel; abort_col >= 0 fires frame_sync at that column
  task automatic run_row(input logic [24:0] bits, input int mean, input bit rnd,
                         input int abort_col, output int first_px, output int last_px);
    int n;
    int budget;
    first_px = -1;
    last_px  = -1;
    budget = 0;
    while (!row_ready && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    if (!row_ready) begin
      chk("row_ready_timeout", 0, 1);
      return;
    end
    row_bits    = bits;
    row_mean    = 8'(mean);
    row_valid   = 1'b1;
    pixel_ready = 1'b0;
    @(negedge clk);
    row_valid = 1'b0;
    row_bits  = 25'($urandom);
    row_mean  = 8'($urandom);
    n = 0;
    for (int cyc = 0; cyc < 300 && n < W; cyc++) begin
      if (cyc > 0) @(negedge clk);
      chk("pixel_valid", int'(pixel_valid), 1);
      chk("pixel_out", int'(pixel_out), exp_pix(bits, mean, n));
      chk("col_idx", int'(col_idx), n);
      chk("row_idx", int'(row_idx), model_row);
      chk("pixel_last_col", int'(last_col), int'(n == W - 1));
      chk("frame_end", int'(frame_end), int'(n == W - 1 && model_row == H - 1));
      chk("row_ready_busy", int'(row_ready), 0);
      if (n == 0) first_px = int'(pixel_out);
      if (n == W - 1) last_px = int'(pixel_out);
      if (n == abort_col) begin
        // Handshake and a competing row in the sync cycle must both be dropped
        frame_sync  = 1'b1;
        pixel_ready = 1'b1;
        row_valid   = 1'b1;
        @(negedge clk);
        frame_sync = 1'b0;
        row_valid  = 1'b0;
        model_row  = 0;
        chk("sync_pixel_valid", int'(pixel_valid), 0);
        chk("sync_row_idx", int'(row_idx), 0);
        chk("sync_col_idx", int'(col_idx), 0);
        chk("sync_row_ready", int'(row_ready), 1);
        chk("sync_last_col", int'(last_col), 0);
        chk("sync_frame_end", int'(frame_end), 0);
        @(negedge clk);
        chk("sync_no_residual", int'(pixel_valid), 0);
        return;
      end
      pixel_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (pixel_valid && pixel_ready) n++;
    end
    if (n < W) chk("row_emit_timeout", n, W);
    @(negedge clk);
    chk("pixel_valid_after_row", int'(pixel_valid), 0);
    chk("row_ready_after_row", int'(row_ready), 1);
    model_row = (model_row + 1) % H;
  endtask

  initial begin
    int fp;
    int lp;
    vecs[0] = '{bits: 25'h1555555, mean: 100, rnd: 1'b0, exp_first: 132, exp_last: 132};
    vecs[1] = '{bits: 25'h1FFFFFF, mean: 240, rnd: 1'b0, exp_first: 255, exp_last: 255};
    vecs[2] = '{bits: 25'h0000000, mean: 10,  rnd: 1'b0, exp_first: 0,   exp_last: 0};
    vecs[3] = '{bits: 25'h1555555, mean: 100, rnd: 1'b1, exp_first: 132, exp_last: 132};
    vecs[4] = '{bits: 25'h0AAAAAA, mean: 31,  rnd: 1'b1, exp_first: 0,   exp_last: 0};
    vecs[5] = '{bits: 25'h1000001, mean: 224, rnd: 1'b0, exp_first: 255, exp_last: 255};

    rst_n       = 1'b0;
    frame_sync  = 1'b0;
    row_bits    = '0;
    row_mean    = '0;
    row_valid   = 1'b0;
    pixel_ready = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_row_ready", int'(row_ready), 0);
    chk("rst_pixel_valid", int'(pixel_valid), 0);
    chk("rst_pixel_out", int'(pixel_out), 0);
    chk("rst_row_idx", int'(row_idx), 0);
    chk("rst_col_idx", int'(col_idx), 0);
    chk("rst_last_col", int'(last_col), 0);
    chk("rst_frame_end", int'(frame_end), 0);
    rst_n = 1'b1;
    chk("release_row_ready", int'(row_ready), 0);
    @(negedge clk);
    chk("release_row_ready_next", int'(row_ready), 1);

    for (int i = 0; i < 6; i++) begin
      run_row(vecs[i].bits, vecs[i].mean, vecs[i].rnd, -1, fp, lp);
      chk("table_first_px", fp, vecs[i].exp_first);
      chk("table_last_px", lp, vecs[i].exp_last);
    end

    // Full frame with mean = row*8, then one more row after the wrap
    pulse_sync();
    for (int r = 0; r < H; r++) begin
      run_row(25'($urandom), r * 8, bit'(r % 2), -1, fp, lp);
    end
    chk("frame_wrap_row_idx", int'(row_idx), 0);
    run_row(25'($urandom), 77, 1'b1, -1, fp, lp);

    // frame_sync at column 10 of row 3
    pulse_sync();
    for (int r = 0; r < 3; r++) run_row(25'($urandom), 50 + r, 1'b0, -1, fp, lp);
    run_row(25'($urandom), 120, 1'b1, 10, fp, lp);
    // frame_sync while idle must also block a row offered in the same cycle
    row_valid  = 1'b1;
    frame_sync = 1'b1;
    @(negedge clk);
    row_valid  = 1'b0;
    frame_sync = 1'b0;
    chk("idle_sync_row_ready", int'(row_ready), 1);
    chk("idle_sync_pixel_valid", int'(pixel_valid), 0);
    run_row(25'h1234567, 200, 1'b0, -1, fp, lp);

    // Reset in the middle of a row discards it
    row_bits    = 25'h1FFFFFF;
    row_mean    = 8'd90;
    row_valid   = 1'b1;
    pixel_ready = 1'b1;
    @(negedge clk);
    row_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_pixel_valid", int'(pixel_valid), 0);
    chk("midrst_row_ready", int'(row_ready), 0);
    chk("midrst_col_idx", int'(col_idx), 0);
    chk("midrst_row_idx", int'(row_idx), 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_row = 0;
    @(negedge clk);
    chk("midrst_row_ready_next", int'(row_ready), 1);
    run_row(25'h0F0F0F0, 128, 1'b1, -1, fp, lp);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
